// File: rtl/synth_pkg.sv
// Shared synthesiser definitions: voice count, note width, allocator state
// encoding and the LRU rank type. Also used by the sound/mixer blocks.
package synth_pkg;

    localparam int NUM_VOICES  = 4;
    localparam int NOTE_W      = 7;
    localparam int VOICE_IDX_W = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        COMMIT = 2'd2
    } alloc_state_e;

    // 0 = most recently triggered, NUM_VOICES-1 = oldest
    typedef logic [1:0] rank_t;
    typedef logic [VOICE_IDX_W-1:0] voice_idx_t;

    // Index of the lowest set bit; 0 when the vector is empty.
    function automatic voice_idx_t lowest_set(input logic [NUM_VOICES-1:0] vec);
        voice_idx_t idx;
        idx = '0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (vec[i]) idx = voice_idx_t'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/voice_lru.sv
// Least-recently-triggered tracker for the four voices.
// Ports:
//   clk, rst_n    clock, async active-low reset
//   touch_i       strobe: the voice at touch_idx_i was just triggered
//   touch_idx_i   voice index being triggered
//   oldest_o      index of the voice holding the oldest rank
//   rank_o        per-voice rank, element 0 = voice 1
module voice_lru
    import synth_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        touch_i,
    input  voice_idx_t                  touch_idx_i,
    output voice_idx_t                  oldest_o,
    output rank_t [NUM_VOICES-1:0]      rank_o
);

    rank_t [NUM_VOICES-1:0] rank_q;
    rank_t [NUM_VOICES-1:0] rank_d;

    // Touched voice goes to rank 0; only voices that were newer than it age
    // by one, so the ranks remain a permutation of 0..NUM_VOICES-1.
    always_comb begin
        rank_d = rank_q;
        if (touch_i) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (i == int'(touch_idx_i)) begin
                    rank_d[i] = '0;
                end else if (rank_q[i] < rank_q[touch_idx_i]) begin
                    rank_d[i] = rank_q[i] + rank_t'(1);
                end
            end
        end
    end

    always_comb begin
        oldest_o = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (rank_q[i] == rank_t'(NUM_VOICES - 1)) oldest_o = voice_idx_t'(i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_VOICES; i++) rank_q[i] <= rank_t'(i);
        end else begin
            rank_q <= rank_d;
        end
    end

    assign rank_o = rank_q;

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice scheduler: maps note-on/off events onto four sine_nco voices.
// Note-ons reuse a voice already sounding the same note, else take the lowest
// free voice, else steal the oldest voice (or drop the event when stealing is
// disabled). Note-offs release every gated voice holding that note.
//
// state  | meaning
// IDLE   | ready; an event is captured on valid
// SCAN   | register match vector, first free voice and oldest voice
// COMMIT | update notes/gates/ranks, pulse steal_o or drop_o
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   ev_valid_i/ready_o  event handshake (ready only in IDLE)
//   ev_on_i, ev_note_i, ev_vel_i  event fields (vel 0 note-on = note-off)
//   all_off_i           release every voice, abort any in-flight event
//   note1_o..note4_o    note per voice
//   gate_o              per-voice gate, bit0 = voice 1
//   steal_o, drop_o     one-cycle event outcome pulses
module voice_allocator #(
    parameter int NOTE_W   = synth_pkg::NOTE_W,
    parameter bit STEAL_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ev_valid_i,
    output logic              ev_ready_o,
    input  logic              ev_on_i,
    input  logic [NOTE_W-1:0] ev_note_i,
    input  logic [6:0]        ev_vel_i,
    input  logic              all_off_i,
    output logic [NOTE_W-1:0] note1_o,
    output logic [NOTE_W-1:0] note2_o,
    output logic [NOTE_W-1:0] note3_o,
    output logic [NOTE_W-1:0] note4_o,
    output logic [3:0]        gate_o,
    output logic              steal_o,
    output logic              drop_o
);
    import synth_pkg::*;

    alloc_state_e state_q, state_d;

    logic              ev_on_q, ev_on_d;
    logic [NOTE_W-1:0] ev_note_q, ev_note_d;

    logic [NUM_VOICES-1:0][NOTE_W-1:0] note_q, note_d;
    logic [NUM_VOICES-1:0]             gate_q, gate_d;

    logic [NUM_VOICES-1:0] match_q, match_d;
    logic                  free_any_q, free_any_d;
    voice_idx_t            free_idx_q, free_idx_d;
    voice_idx_t            oldest_q, oldest_d;

    logic steal_q, steal_d;
    logic drop_q, drop_d;

    logic                   touch;
    voice_idx_t             touch_idx;
    voice_idx_t             lru_oldest;
    rank_t [NUM_VOICES-1:0] lru_rank;
    logic [NUM_VOICES-1:0]  scan_match;
    logic                   steal_ok;

    voice_lru u_lru (
        .clk        (clk),
        .rst_n      (rst_n),
        .touch_i    (touch),
        .touch_idx_i(touch_idx),
        .oldest_o   (lru_oldest),
        .rank_o     (lru_rank)
    );

    always_comb begin
        for (int i = 0; i < NUM_VOICES; i++) begin
            scan_match[i] = gate_q[i] && (note_q[i] == ev_note_q);
        end
    end

    // Ranks cannot move between SCAN and COMMIT, so the captured oldest
    // pointer must still hold the top rank; guards a steal against a
    // corrupted pointer.
    assign steal_ok = (lru_rank[oldest_q] == rank_t'(NUM_VOICES - 1));

    always_comb begin
        state_d    = state_q;
        ev_on_d    = ev_on_q;
        ev_note_d  = ev_note_q;
        note_d     = note_q;
        gate_d     = gate_q;
        match_d    = match_q;
        free_any_d = free_any_q;
        free_idx_d = free_idx_q;
        oldest_d   = oldest_q;
        steal_d    = 1'b0;
        drop_d     = 1'b0;
        touch      = 1'b0;
        touch_idx  = '0;

        case (state_q)
            IDLE: begin
                if (ev_valid_i) begin
                    state_d   = SCAN;
                    ev_on_d   = ev_on_i && (ev_vel_i != 7'd0);
                    ev_note_d = ev_note_i;
                end
            end
            SCAN: begin
                match_d    = scan_match;
                free_any_d = ~&gate_q;
                free_idx_d = lowest_set(~gate_q);
                oldest_d   = lru_oldest;
                state_d    = COMMIT;
            end
            COMMIT: begin
                state_d = IDLE;
                if (ev_on_q) begin
                    if (|match_q) begin
                        touch     = 1'b1;
                        touch_idx = lowest_set(match_q);
                    end else if (free_any_q) begin
                        touch     = 1'b1;
                        touch_idx = free_idx_q;
                    end else if (STEAL_EN && steal_ok) begin
                        touch     = 1'b1;
                        touch_idx = oldest_q;
                        steal_d   = 1'b1;
                    end else begin
                        drop_d = 1'b1;
                    end
                    if (touch) begin
                        gate_d[touch_idx] = 1'b1;
                        note_d[touch_idx] = ev_note_q;
                    end
                end else begin
                    gate_d = gate_q & ~match_q;
                end
            end
            default: state_d = IDLE;
        endcase

        // all-off overrides everything, including a capture in IDLE
        if (all_off_i) begin
            state_d = IDLE;
            gate_d  = '0;
            note_d  = note_q;
            steal_d = 1'b0;
            drop_d  = 1'b0;
            touch   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ev_on_q    <= 1'b0;
            ev_note_q  <= '0;
            note_q     <= '0;
            gate_q     <= '0;
            match_q    <= '0;
            free_any_q <= 1'b0;
            free_idx_q <= '0;
            oldest_q   <= '0;
            steal_q    <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ev_on_q    <= ev_on_d;
            ev_note_q  <= ev_note_d;
            note_q     <= note_d;
            gate_q     <= gate_d;
            match_q    <= match_d;
            free_any_q <= free_any_d;
            free_idx_q <= free_idx_d;
            oldest_q   <= oldest_d;
            steal_q    <= steal_d;
            drop_q     <= drop_d;
        end
    end

    assign ev_ready_o = (state_q == IDLE);
    assign note1_o    = note_q[0];
    assign note2_o    = note_q[1];
    assign note3_o    = note_q[2];
    assign note4_o    = note_q[3];
    assign gate_o     = gate_q;
    assign steal_o    = steal_q;
    assign drop_o     = drop_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Bench for voice_allocator: two instances (stealing on / off) share one
// stimulus stream and are checked every cycle against a list-based model.
module tb_voice_allocator;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ev_valid_i;
    logic       ev_on_i;
    logic [6:0] ev_note_i;
    logic [6:0] ev_vel_i;
    logic       all_off_i;

    logic [1:0]            ready_o;
    logic [1:0][3:0][6:0]  note_o;
    logic [1:0][3:0]       gate_o;
    logic [1:0]            steal_o;
    logic [1:0]            drop_o;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    voice_allocator #(.NOTE_W(7), .STEAL_EN(1'b1)) dut_steal (
        .clk(clk), .rst_n(rst_n),
        .ev_valid_i(ev_valid_i), .ev_ready_o(ready_o[0]),
        .ev_on_i(ev_on_i), .ev_note_i(ev_note_i), .ev_vel_i(ev_vel_i),
        .all_off_i(all_off_i),
        .note1_o(note_o[0][0]), .note2_o(note_o[0][1]),
        .note3_o(note_o[0][2]), .note4_o(note_o[0][3]),
        .gate_o(gate_o[0]), .steal_o(steal_o[0]), .drop_o(drop_o[0])
    );

    voice_allocator #(.NOTE_W(7), .STEAL_EN(1'b0)) dut_drop (
        .clk(clk), .rst_n(rst_n),
        .ev_valid_i(ev_valid_i), .ev_ready_o(ready_o[1]),
        .ev_on_i(ev_on_i), .ev_note_i(ev_note_i), .ev_vel_i(ev_vel_i),
        .all_off_i(all_off_i),
        .note1_o(note_o[1][0]), .note2_o(note_o[1][1]),
        .note3_o(note_o[1][2]), .note4_o(note_o[1][3]),
        .gate_o(gate_o[1]), .steal_o(steal_o[1]), .drop_o(drop_o[1])
    );

    // ---------------- reference model ----------------
    // m_order[d] lists voice numbers from most recently triggered to oldest.
    int m_note  [2][4];
    bit m_gate  [2][4];
    int m_order [2][4];
    bit m_steal [2];
    bit m_drop  [2];
    int m_busy;          // cycles until the pending event takes effect
    bit p_on;
    int p_note;

    function automatic void m_reset();
        for (int d = 0; d < 2; d++) begin
            for (int v = 0; v < 4; v++) begin
                m_note[d][v]  = 0;
                m_gate[d][v]  = 1'b0;
                m_order[d][v] = v;
            end
            m_steal[d] = 1'b0;
            m_drop[d]  = 1'b0;
        end
        m_busy = 0;
        p_on   = 1'b0;
        p_note = 0;
    endfunction

    function automatic void move_front(input int d, input int v);
        int p;
        p = 0;
        for (int i = 0; i < 4; i++) if (m_order[d][i] == v) p = i;
        for (int k = p; k > 0; k--) m_order[d][k] = m_order[d][k-1];
        m_order[d][0] = v;
    endfunction

    function automatic void apply(input int d, input bit steal_en);
        int t;
        t = -1;
        for (int v = 0; v < 4; v++)
            if (t < 0 && m_gate[d][v] && m_note[d][v] == p_note) t = v;
        if (p_on) begin
            for (int v = 0; v < 4; v++)
                if (t < 0 && !m_gate[d][v]) t = v;
            if (t < 0) begin
                if (steal_en) begin
                    t = m_order[d][3];
                    m_steal[d] = 1'b1;
                end else begin
                    m_drop[d] = 1'b1;
                end
            end
            if (t >= 0) begin
                m_gate[d][t] = 1'b1;
                m_note[d][t] = p_note;
                move_front(d, t);
            end
        end else begin
            for (int v = 0; v < 4; v++)
                if (m_gate[d][v] && m_note[d][v] == p_note) m_gate[d][v] = 1'b0;
        end
    endfunction

    initial m_reset();

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_reset();
        end else begin
            for (int d = 0; d < 2; d++) begin
                m_steal[d] = 1'b0;
                m_drop[d]  = 1'b0;
            end
            if (all_off_i) begin
                for (int d = 0; d < 2; d++)
                    for (int v = 0; v < 4; v++) m_gate[d][v] = 1'b0;
                m_busy = 0;
            end else if (m_busy == 0) begin
                if (ev_valid_i) begin
                    p_on   = ev_on_i && (ev_vel_i != 7'd0);
                    p_note = int'(ev_note_i);
                    m_busy = 2;
                end
            end else begin
                m_busy--;
                if (m_busy == 0) begin
                    apply(0, 1'b1);
                    apply(1, 1'b0);
                end
            end
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            int g;
            g = 0;
            for (int v = 0; v < 4; v++) if (m_gate[d][v]) g |= (1 << v);
            chk($sformatf("d%0d_ready", d), int'(ready_o[d]), (m_busy == 0) ? 1 : 0);
            chk($sformatf("d%0d_gate", d), int'(gate_o[d]), g);
            chk($sformatf("d%0d_steal", d), int'(steal_o[d]), int'(m_steal[d]));
            chk($sformatf("d%0d_drop", d), int'(drop_o[d]), int'(m_drop[d]));
            for (int v = 0; v < 4; v++)
                chk($sformatf("d%0d_note%0d", d, v + 1), int'(note_o[d][v]), m_note[d][v]);
        end
    end

    task automatic chk_v(input int d, input string tag, input int n1, input int n2,
                         input int n3, input int n4, input int g, input int st, input int dr);
        chk({tag, "_note1"}, int'(note_o[d][0]), n1);
        chk({tag, "_note2"}, int'(note_o[d][1]), n2);
        chk({tag, "_note3"}, int'(note_o[d][2]), n3);
        chk({tag, "_note4"}, int'(note_o[d][3]), n4);
        chk({tag, "_gate"},  int'(gate_o[d]), g);
        chk({tag, "_steal"}, int'(steal_o[d]), st);
        chk({tag, "_drop"},  int'(drop_o[d]), dr);
    endtask

    // Issues one event and returns #1 after the edge that leaves COMMIT.
    task automatic send(input bit on, input int note, input int vel);
        int waited;
        waited = 0;
        @(negedge clk);
        while (!ready_o[0] && waited < 8) begin
            @(negedge clk);
            waited++;
        end
        if (!ready_o[0]) chk("ready_timeout", int'(ready_o[0]), 1);
        ev_valid_i = 1'b1;
        ev_on_i    = on;
        ev_note_i  = 7'(note);
        ev_vel_i   = 7'(vel);
        @(posedge clk); #1;
        ev_valid_i = 1'b0;
        chk("busy_after_accept", int'(ready_o[0]), 0);
        @(posedge clk); #1;
        chk("busy_in_commit", int'(ready_o[0]), 0);
        @(posedge clk); #1;
        chk("ready_after_commit", int'(ready_o[0]), 1);
    endtask

    int pool [8] = '{0, 60, 61, 62, 63, 64, 65, 127};

    initial begin
        rst_n      = 1'b0;
        ev_valid_i = 1'b0;
        ev_on_i    = 1'b0;
        ev_note_i  = '0;
        ev_vel_i   = '0;
        all_off_i  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_v(0, "rst0", 0, 0, 0, 0, 0, 0, 0);
        chk("rst0_ready", int'(ready_o[0]), 1);
        chk_v(1, "rst1", 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;

        // fill all four voices
        send(1'b1, 60, 100);
        send(1'b1, 64, 100);
        send(1'b1, 67, 100);
        send(1'b1, 72, 100);
        chk_v(0, "t1_s", 60, 64, 67, 72, 15, 0, 0);
        chk_v(1, "t1_d", 60, 64, 67, 72, 15, 0, 0);

        // full: steal oldest (voice 1 then voice 2) or drop
        send(1'b1, 76, 90);
        chk_v(0, "t2a_s", 76, 64, 67, 72, 15, 1, 0);
        chk_v(1, "t2a_d", 60, 64, 67, 72, 15, 0, 1);
        send(1'b1, 79, 90);
        chk_v(0, "t2b_s", 76, 79, 67, 72, 15, 1, 0);
        chk_v(1, "t2b_d", 60, 64, 67, 72, 15, 0, 1);

        // note-off keeps the note, freed voice refilled without steal
        send(1'b0, 64, 0);
        chk_v(0, "t3a_s", 76, 79, 67, 72, 15, 0, 0);
        chk_v(1, "t3a_d", 60, 64, 67, 72, 13, 0, 0);
        send(1'b0, 79, 50);
        chk_v(0, "t3b_s", 76, 79, 67, 72, 13, 0, 0);
        chk_v(1, "t3b_d", 60, 64, 67, 72, 13, 0, 0);
        send(1'b1, 50, 80);
        chk_v(0, "t3c_s", 76, 50, 67, 72, 15, 0, 0);
        chk_v(1, "t3c_d", 60, 50, 67, 72, 15, 0, 0);

        // retrigger voice 3; it becomes newest so voice 4 is stolen next
        send(1'b1, 67, 70);
        chk_v(0, "t4a_s", 76, 50, 67, 72, 15, 0, 0);
        chk_v(1, "t4a_d", 60, 50, 67, 72, 15, 0, 0);
        send(1'b1, 90, 70);
        chk_v(0, "t4b_s", 76, 50, 67, 90, 15, 1, 0);
        chk_v(1, "t4b_d", 60, 50, 67, 72, 15, 0, 1);

        // velocity-0 note-on releases
        send(1'b1, 60, 0);
        chk_v(0, "t5_s", 76, 50, 67, 90, 15, 0, 0);
        chk_v(1, "t5_d", 60, 50, 67, 72, 14, 0, 0);

        // all-off during SCAN
        @(negedge clk);
        ev_valid_i = 1'b1; ev_on_i = 1'b1; ev_note_i = 7'd33; ev_vel_i = 7'd100;
        @(posedge clk); #1;
        ev_valid_i = 1'b0;
        all_off_i  = 1'b1;
        @(posedge clk); #1;
        all_off_i  = 1'b0;
        chk("t6_gate_s", int'(gate_o[0]), 0);
        chk("t6_gate_d", int'(gate_o[1]), 0);
        chk("t6_ready", int'(ready_o[0]), 1);
        repeat (3) @(posedge clk);
        #1;
        chk_v(0, "t6_s", 76, 50, 67, 90, 0, 0, 0);
        chk_v(1, "t6_d", 60, 50, 67, 72, 0, 0, 0);

        // all-off coinciding with an accept discards the event
        send(1'b1, 33, 100);
        chk_v(0, "t7a_s", 33, 50, 67, 90, 1, 0, 0);
        @(negedge clk);
        ev_valid_i = 1'b1; ev_on_i = 1'b1; ev_note_i = 7'd44; ev_vel_i = 7'd100;
        all_off_i  = 1'b1;
        @(posedge clk); #1;
        ev_valid_i = 1'b0;
        all_off_i  = 1'b0;
        chk("t7_ready", int'(ready_o[0]), 1);
        repeat (3) @(posedge clk);
        #1;
        chk_v(0, "t7b_s", 33, 50, 67, 90, 0, 0, 0);

        // asynchronous reset while in COMMIT
        @(negedge clk);
        ev_valid_i = 1'b1; ev_on_i = 1'b1; ev_note_i = 7'd40; ev_vel_i = 7'd1;
        @(posedge clk); #1;
        ev_valid_i = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk_v(0, "t8_s", 0, 0, 0, 0, 0, 0, 0);
        chk("t8_ready", int'(ready_o[0]), 1);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // randomized traffic
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk); #1;
            ev_valid_i = ($urandom_range(0, 2) != 0);
            ev_on_i    = ($urandom_range(0, 9) < 6);
            ev_note_i  = 7'(pool[$urandom_range(0, 7)]);
            ev_vel_i   = ($urandom_range(0, 9) == 0) ? 7'd0 : 7'($urandom_range(1, 127));
            all_off_i  = ($urandom_range(0, 49) == 0);
            if (c == 2000) begin
                #2 rst_n = 1'b0;
                #4 rst_n = 1'b1;
            end
        end
        @(posedge clk); #1;
        ev_valid_i = 1'b0;
        all_off_i  = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
